// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file: FSM states,
// default geometry and the write-to-read forwarding select.
package regfile_pkg;

    localparam int RF_W_DEFAULT     = 32;
    localparam int RF_DEPTH_DEFAULT = 32;
    localparam int RF_AW_MAX        = 16;

    typedef enum logic {
        RF_CLEAR,
        RF_RUN
    } rf_state_e;

    typedef enum logic [1:0] {
        RF_SEL_MEM,
        RF_SEL_W0,
        RF_SEL_W1
    } rf_sel_e;

    // Write port 1 outranks port 0, matching the storage priority.
    function automatic rf_sel_e rf_lane_sel(
        input logic [RF_AW_MAX-1:0] addr,
        input logic                 we1,
        input logic [RF_AW_MAX-1:0] a1,
        input logic                 we0,
        input logic [RF_AW_MAX-1:0] a0
    );
        rf_sel_e sel;
        sel = RF_SEL_MEM;
        if (we1 && (addr == a1)) begin
            sel = RF_SEL_W1;
        end else if (we0 && (addr == a0)) begin
            sel = RF_SEL_W0;
        end
        return sel;
    endfunction

endpackage

// File: rtl/regfile_sb.sv
// Pending-bit scoreboard: one bit per register, set by issue, cleared by
// write-back, with a per-read-port busy decode that honours forwarding.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int DEPTH    = RF_DEPTH_DEFAULT,
    parameter  int NR       = 2,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             set_en,
    input  logic [AW-1:0]    set_addr,
    input  logic             clr0_en,
    input  logic             clr1_en,
    input  logic             fwd0_en,
    input  logic             fwd1_en,
    input  logic [AW-1:0]    w0_addr,
    input  logic [AW-1:0]    w1_addr,
    input  logic [NR*AW-1:0] raddr,
    output logic [NR-1:0]    rbusy
);

    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pending_d = pending_q;
        if (flush) begin
            pending_d = '0;
        end else begin
            if (clr0_en) pending_d[w0_addr] = 1'b0;
            if (clr1_en) pending_d[w1_addr] = 1'b0;
            // Set is applied last so a newer producer beats a retiring one.
            if (set_en && !((ZERO_REG != 0) && (set_addr == '0))) begin
                pending_d[set_addr] = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    for (genvar i = 0; i < NR; i++) begin : g_busy
        logic [AW-1:0] a;
        rf_sel_e       sel;
        assign a        = raddr[i*AW +: AW];
        assign sel      = rf_lane_sel(RF_AW_MAX'(a), fwd1_en, RF_AW_MAX'(w1_addr),
                                      fwd0_en, RF_AW_MAX'(w0_addr));
        // A value arriving on a write port this cycle is forwarded, so not busy.
        assign rbusy[i] = pending_q[a] && (sel == RF_SEL_MEM);
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NR forwarding read lanes, two prioritised write
// ports, a hazard scoreboard and a clear engine that zeroes the array.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int W        = RF_W_DEFAULT,
    parameter  int DEPTH    = RF_DEPTH_DEFAULT,
    parameter  int NR       = 2,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             oc,
    input  logic             clr_req,
    output logic             ready,
    input  logic [NR*AW-1:0] raddr,
    output logic [NR*W-1:0]  rdata,
    output logic [NR-1:0]    rbusy,
    input  logic             we0,
    input  logic [AW-1:0]    waddr0,
    input  logic [W-1:0]     wdata0,
    input  logic             we1,
    input  logic [AW-1:0]    waddr1,
    input  logic [W-1:0]     wdata1,
    input  logic             sb_set,
    input  logic [AW-1:0]    sb_addr
);

    rf_state_e     state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          clr_wr;
    logic          run;
    logic          fwd0_en, fwd1_en;
    logic          wr0_en, wr1_en;
    logic [W-1:0]  mem_q [DEPTH];

    assign run     = (state_q == RF_RUN);
    assign ready   = run;
    assign fwd0_en = run && we0;
    assign fwd1_en = run && we1;
    assign wr0_en  = fwd0_en && !clr_req && !((ZERO_REG != 0) && (waddr0 == '0));
    assign wr1_en  = fwd1_en && !clr_req && !((ZERO_REG != 0) && (waddr1 == '0));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        clr_wr  = 1'b0;
        case (state_q)
            RF_CLEAR: begin
                clr_wr = 1'b1;
                if (clr_req) begin
                    idx_d = '0;
                end else if (idx_q == AW'(DEPTH - 1)) begin
                    state_d = RF_RUN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            default: begin
                if (clr_req) begin
                    state_d = RF_CLEAR;
                    idx_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RF_CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // NOTE: the array has no reset so it maps onto RAM; the clear engine zeroes it instead.
    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem_q[idx_q] <= '0;
        end else begin
            if (wr0_en) mem_q[waddr0] <= wdata0;
            if (wr1_en) mem_q[waddr1] <= wdata1;
        end
    end

    regfile_sb #(
        .DEPTH    (DEPTH),
        .NR       (NR),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (run && clr_req),
        .set_en   (run && sb_set && !clr_req),
        .set_addr (sb_addr),
        .clr0_en  (wr0_en),
        .clr1_en  (wr1_en),
        .fwd0_en  (fwd0_en),
        .fwd1_en  (fwd1_en),
        .w0_addr  (waddr0),
        .w1_addr  (waddr1),
        .raddr    (raddr),
        .rbusy    (rbusy)
    );

    for (genvar i = 0; i < NR; i++) begin : g_lane
        logic [AW-1:0] a;
        rf_sel_e       sel;
        logic [W-1:0]  lane_val;

        assign a   = raddr[i*AW +: AW];
        assign sel = rf_lane_sel(RF_AW_MAX'(a), fwd1_en, RF_AW_MAX'(waddr1),
                                 fwd0_en, RF_AW_MAX'(waddr0));

        always_comb begin
            lane_val = '0;
            if (run && !((ZERO_REG != 0) && (a == '0))) begin
                case (sel)
                    RF_SEL_W1: lane_val = wdata1;
                    RF_SEL_W0: lane_val = wdata0;
                    default:   lane_val = mem_q[a];
                endcase
            end
        end

        assign rdata[i*W +: W] = oc ? {W{1'bz}} : lane_val;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: table-driven forwarding vectors plus
// hand-written reset, scoreboard and clear-engine sequences.
module tb_regfile_mp;

    localparam int W     = 32;
    localparam int DEPTH = 32;
    localparam int NR    = 2;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             oc;
    logic             clr_req;
    logic             ready;
    logic [NR*AW-1:0] raddr;
    wire  [NR*W-1:0]  rdata;
    logic [NR-1:0]    rbusy;
    logic             we0;
    logic [AW-1:0]    waddr0;
    logic [W-1:0]     wdata0;
    logic             we1;
    logic [AW-1:0]    waddr1;
    logic [W-1:0]     wdata1;
    logic             sb_set;
    logic [AW-1:0]    sb_addr;

    always #5 clk = ~clk;

    regfile_mp #(.W(W), .DEPTH(DEPTH), .NR(NR), .ZERO_REG(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .oc      (oc),
        .clr_req (clr_req),
        .ready   (ready),
        .raddr   (raddr),
        .rdata   (rdata),
        .rbusy   (rbusy),
        .we0     (we0),
        .waddr0  (waddr0),
        .wdata0  (wdata0),
        .we1     (we1),
        .waddr1  (waddr1),
        .wdata1  (wdata1),
        .sb_set  (sb_set),
        .sb_addr (sb_addr)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        name;
        int           lane;
        logic [W-1:0] data;
        logic         busy;
    } exp_t;

    exp_t sbq[$];

    typedef struct {
        logic          we0;
        logic [AW-1:0] wa0;
        logic [W-1:0]  wd0;
        logic          we1;
        logic [AW-1:0] wa1;
        logic [W-1:0]  wd1;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [W-1:0]  exp0;
        logic [W-1:0]  exp1;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_lane(input string name, input int lane, input logic [W-1:0] data,
                               input logic busy);
        exp_t e;
        e.name = name;
        e.lane = lane;
        e.data = data;
        e.busy = busy;
        sbq.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            check({e.name, "_data"}, 64'(rdata[e.lane*W +: W]), 64'(e.data));
            check({e.name, "_busy"}, 64'(rbusy[e.lane]), 64'(e.busy));
        end
    endtask

    // Compare pending expectations mid-cycle, then advance past the next edge.
    task automatic cycle();
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
    endtask

    task automatic set_raddr(input int a0, input int a1);
        raddr = {AW'(a1), AW'(a0)};
    endtask

    task automatic idle();
        oc      = 1'b0;
        clr_req = 1'b0;
        we0     = 1'b0;
        waddr0  = '0;
        wdata0  = '0;
        we1     = 1'b0;
        waddr1  = '0;
        wdata1  = '0;
        sb_set  = 1'b0;
        sb_addr = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  5'd6,  32'hDEADBEEF, 32'h0};
        vecs[2]  = '{1'b1, 5'd7,  32'h11,       1'b1, 5'd7,  32'h22,       5'd7,  5'd5,  32'h22,       32'hDEADBEEF};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h22,       32'h22};
        vecs[4]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
        vecs[6]  = '{1'b1, 5'd10, 32'hA5A5A5A5, 1'b1, 5'd11, 32'h12345678, 5'd10, 5'd11, 32'hA5A5A5A5, 32'h12345678};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd10, 5'd11, 32'hA5A5A5A5, 32'h12345678};
        vecs[8]  = '{1'b1, 5'd12, 32'h1,        1'b1, 5'd13, 32'h2,        5'd12, 5'd13, 32'h1,        32'h2};
        vecs[9]  = '{1'b1, 5'd5,  32'hCAFEF00D, 1'b1, 5'd7,  32'h33,       5'd5,  5'd7,  32'hCAFEF00D, 32'h33};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  5'd7,  32'hCAFEF00D, 32'h33};
        vecs[11] = '{1'b1, 5'd14, 32'hBB,       1'b0, 5'd0,  32'h0,        5'd15, 5'd14, 32'h0,        32'hBB};

        // Reset and clear-engine start-up.
        rst_n = 1'b0;
        idle();
        set_raddr(1, 2);
        repeat (3) @(posedge clk);
        #1;
        check("ready_in_reset", 64'(ready), 64'(1'b0));
        rst_n = 1'b1;
        check("ready_after_release", 64'(ready), 64'(1'b0));
        for (int e = 1; e <= DEPTH; e++) begin
            // Writes and sb_set during the clear must leave no trace.
            we0     = 1'b1;
            waddr0  = 5'd1;
            wdata0  = 32'hAAAA0001;
            sb_set  = 1'b1;
            sb_addr = 5'd2;
            expect_lane("clr_l0", 0, '0, 1'b0);
            expect_lane("clr_l1", 1, '0, 1'b0);
            @(negedge clk);
            drain();
            @(posedge clk);
            #1;
            check($sformatf("ready_edge%0d", e), 64'(ready), 64'(e == DEPTH));
        end
        idle();

        for (int r = 0; r < DEPTH; r += 2) begin
            set_raddr(r, r + 1);
            expect_lane($sformatf("init_r%0d", r), 0, '0, 1'b0);
            expect_lane($sformatf("init_r%0d", r + 1), 1, '0, 1'b0);
            cycle();
        end

        // Forwarding and write-priority vectors.
        for (int i = 0; i < 12; i++) begin
            we0    = vecs[i].we0;
            waddr0 = vecs[i].wa0;
            wdata0 = vecs[i].wd0;
            we1    = vecs[i].we1;
            waddr1 = vecs[i].wa1;
            wdata1 = vecs[i].wd1;
            raddr  = {vecs[i].ra1, vecs[i].ra0};
            expect_lane($sformatf("vec%0d_l0", i), 0, vecs[i].exp0, 1'b0);
            expect_lane($sformatf("vec%0d_l1", i), 1, vecs[i].exp1, 1'b0);
            cycle();
        end
        idle();

        // Output control: lanes float; a two-state simulator resolves them to 0.
        set_raddr(5, 7);
        oc = 1'b1;
        @(negedge clk);
        checks++;
        if (!((rdata === {NR*W{1'bz}}) || (rdata === '0))) begin
            errors++;
            $display("FAIL oc_highz: got %h expected all z", rdata);
        end
        @(posedge clk);
        #1;
        oc = 1'b0;
        expect_lane("oc_off_l0", 0, 32'hCAFEF00D, 1'b0);
        expect_lane("oc_off_l1", 1, 32'h33, 1'b0);
        cycle();

        // Scoreboard set/clear ordering.
        set_raddr(3, 0);
        sb_set  = 1'b1;
        sb_addr = 5'd3;
        expect_lane("sb_set_l0", 0, '0, 1'b0);
        cycle();
        sb_set = 1'b0;
        expect_lane("sb_pend_l0", 0, '0, 1'b1);
        cycle();
        we1     = 1'b1;
        waddr1  = 5'd3;
        wdata1  = 32'h77;
        sb_set  = 1'b1;
        sb_addr = 5'd3;
        expect_lane("sb_fwd_l0", 0, 32'h77, 1'b0);
        cycle();
        idle();
        expect_lane("sb_setwins_l0", 0, 32'h77, 1'b1);
        cycle();
        we0    = 1'b1;
        waddr0 = 5'd3;
        wdata0 = 32'h88;
        expect_lane("sb_wr_l0", 0, 32'h88, 1'b0);
        cycle();
        idle();
        sb_set  = 1'b1;
        sb_addr = 5'd0;
        expect_lane("sb_done_l0", 0, 32'h88, 1'b0);
        cycle();
        sb_set = 1'b0;
        expect_lane("sb_r0_l1", 1, '0, 1'b0);
        cycle();

        // Clear request mid-run.
        we1     = 1'b1;
        waddr1  = 5'd9;
        wdata1  = 32'h55;
        sb_set  = 1'b1;
        sb_addr = 5'd4;
        set_raddr(9, 4);
        expect_lane("pre_clr_l0", 0, 32'h55, 1'b0);
        expect_lane("pre_clr_l1", 1, '0, 1'b0);
        cycle();
        idle();
        expect_lane("pre_clr_r9", 0, 32'h55, 1'b0);
        expect_lane("pre_clr_r4", 1, '0, 1'b1);
        cycle();
        clr_req = 1'b1;
        we0     = 1'b1;
        waddr0  = 5'd9;
        wdata0  = 32'hAA;
        @(posedge clk);
        #1;
        idle();
        for (int k = 0; k < DEPTH; k++) begin
            check($sformatf("clr_ready%0d", k), 64'(ready), 64'(1'b0));
            we1     = 1'b1;
            waddr1  = 5'd9;
            wdata1  = 32'h99;
            sb_set  = 1'b1;
            sb_addr = 5'd9;
            set_raddr(9, 4);
            expect_lane("clr_run_l0", 0, '0, 1'b0);
            expect_lane("clr_run_l1", 1, '0, 1'b0);
            cycle();
        end
        idle();
        check("clr_ready_back", 64'(ready), 64'(1'b1));
        set_raddr(9, 4);
        expect_lane("post_clr_r9", 0, '0, 1'b0);
        expect_lane("post_clr_r4", 1, '0, 1'b0);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
